sdb_to_bin_conv: RTL

//  Converts a signed-digit (SD) operand, as produced by the sdb adder datapath, back to plain two's complement.

---
 rtl/sdb_to_bin_conv.sv | 85 ++++++++
 1 files changed

// File: rtl/sdb_to_bin_conv.sv
// sdb_to_bin_conv: serial signed-digit to two's complement converter (optional SDB_CONV_EARLY_EXIT_EN)
module sdb_to_bin_conv #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dp,
    input  logic [WIDTH-1:0] dn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   res,
    output logic             res_neg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pd, nd, r, r_next;
    logic [IW-1:0]    idx;
    logic             borrow, last;
    logic [CHUNK:0]   diff;

    assign in_ready = state == IDLE;
    assign res_neg  = res[WIDTH];
    assign diff     = {1'b0, pd[CHUNK-1:0]} - {1'b0, nd[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow};

    // chunks above the current one are pre-filled with the new borrow, which is
    // exactly the sign extension needed when no set digits remain
    always_comb begin
        r_next = r;
        for (int j = 0; j < N; j++)
            if (IW'(j) == idx) r_next[j*CHUNK +: CHUNK] = diff[CHUNK-1:0];
            else if (IW'(j) > idx) r_next[j*CHUNK +: CHUNK] = {CHUNK{diff[CHUNK]}};
    end

`ifdef SDB_CONV_EARLY_EXIT_EN
    assign last = idx == IW'(N - 1) || ~|((pd | nd) >> CHUNK);
`else
    assign last = idx == IW'(N - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            borrow    <= 1'b0;
            idx       <= '0;
            pd        <= '0;
            nd        <= '0;
            r         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    pd     <= dp;
                    nd     <= dn;
                    borrow <= 1'b0;
                    idx    <= '0;
                    state  <= CONV;
                end
                CONV: begin
                    pd     <= pd >> CHUNK;
                    nd     <= nd >> CHUNK;
                    r      <= r_next;
                    borrow <= diff[CHUNK];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        res       <= {diff[CHUNK], r_next};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
